shake_xof_squeezer: RTL

Sponge controller that drives the Keccak-f[1600] `permutation` core from the other side of its enable/valid interface. It absorbs one pre-sized seed with SHAKE domain padding, launches the permutation, and reads back the state. It then squeezes the rate portion as a stream of 64-bit lanes under valid/ready flow control, re-permuting whenever the rate is exhausted. It sits between the Kyber sampling logic (SampleNTT/CBD consumers) and the permutation core.

---
 rtl/keccak_pkg.sv | 20 ++
 rtl/shake_xof_squeezer_if.sv | 25 ++
 rtl/shake_pad.sv | 24 ++
 rtl/shake_xof_squeezer.sv | 101 ++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] definitions for the sponge controller and the permutation core.
package keccak_pkg;

    localparam int unsigned KECCAK_STATE_W = 1600;
    localparam int unsigned LANE_W         = 64;
    localparam int unsigned NUM_LANES      = 25;

    typedef enum logic [1:0] {
        IDLE,
        PRST,
        PERM,
        SQUEEZE
    } sponge_state_e;

    // Lane (x, y) sits at bit offset LANE_W * (x + 5y) in the packed state.
    function automatic int unsigned lane_index(input int unsigned x, input int unsigned y);
        return x + 5 * y;
    endfunction

endpackage

// File: rtl/shake_xof_squeezer_if.sv
// Seed-in / lane-out bus between the Kyber samplers and the SHAKE squeezer.
interface shake_xof_squeezer_if #(
    parameter int unsigned MSG_BYTES = 34
);
    localparam int unsigned MSG_W = (MSG_BYTES == 0) ? 8 : 8 * MSG_BYTES;

    logic             start;
    logic [MSG_W-1:0] msg_in;
    logic             stop;
    logic [63:0]      dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;

    modport master (
        output start, msg_in, stop, dout_ready,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  start, msg_in, stop, dout_ready,
        output dout, dout_valid, busy
    );

endinterface

// File: rtl/shake_pad.sv
// Forms the first absorbed sponge state: seed bytes, domain byte, and the final 0x80 pad bit.
module shake_pad
    import keccak_pkg::*;
#(
    parameter int unsigned RATE_BYTES = 168,
    parameter int unsigned MSG_BYTES  = 34,
    parameter logic [7:0]  DOMAIN_PAD = 8'h1F,
    parameter int unsigned MSG_W      = 272
) (
    input  logic [MSG_W-1:0]          msg_i,
    output logic [KECCAK_STATE_W-1:0] state_o
);

    // Seed into the low bytes, then XOR both pads so they merge when they share a byte.
    always_comb begin
        state_o = '0;
        for (int k = 0; k < int'(MSG_BYTES); k++) begin
            state_o[8*k +: 8] = msg_i[8*k +: 8];
        end
        state_o[8*MSG_BYTES +: 8] = state_o[8*MSG_BYTES +: 8] ^ DOMAIN_PAD;
        state_o[8*(RATE_BYTES-1) +: 8] = state_o[8*(RATE_BYTES-1) +: 8] ^ 8'h80;
    end

endmodule

// File: rtl/shake_xof_squeezer.sv
// SHAKE sponge controller: absorbs one padded seed, drives the permutation core, and
// streams the rate portion out as 64-bit lanes, re-permuting when the rate runs out.
module shake_xof_squeezer
    import keccak_pkg::*;
#(
    parameter int unsigned RATE_BYTES = 168,
    parameter int unsigned MSG_BYTES  = 34,
    parameter logic [7:0]  DOMAIN_PAD = 8'h1F
) (
    input  logic                      clk,
    input  logic                      rst,
    shake_xof_squeezer_if.slave       bus,
    output logic                      perm_rst,
    output logic                      perm_enable,
    output logic [KECCAK_STATE_W-1:0] perm_in,
    input  logic [KECCAK_STATE_W-1:0] perm_state,
    input  logic                      perm_valid
);

    localparam int unsigned MSG_W      = (MSG_BYTES == 0) ? 8 : 8 * MSG_BYTES;
    localparam int unsigned RATE_LANES = RATE_BYTES / 8;
    localparam logic [4:0]  LAST_LANE  = 5'(RATE_LANES - 1);

    sponge_state_e             state_q, state_d;
    logic [KECCAK_STATE_W-1:0] s_q, s_d;
    logic [KECCAK_STATE_W-1:0] pad_state;
    logic [4:0]                cnt_q, cnt_d;

    shake_pad #(
        .RATE_BYTES (RATE_BYTES),
        .MSG_BYTES  (MSG_BYTES),
        .DOMAIN_PAD (DOMAIN_PAD),
        .MSG_W      (MSG_W)
    ) u_pad (
        .msg_i   (bus.msg_in),
        .state_o (pad_state)
    );

    // Next-state: stop overrides everything; perm_valid only matters while in PERM.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        s_d     = pad_state;
                        state_d = PRST;
                    end
                end
                PRST: state_d = PERM;
                PERM: begin
                    if (perm_valid) begin
                        s_d     = perm_state;
                        cnt_d   = '0;
                        state_d = SQUEEZE;
                    end
                end
                SQUEEZE: begin
                    if (bus.dout_ready) begin
                        if (cnt_q == LAST_LANE) begin
                            // Rate exhausted: permute the whole state again, nothing absorbed.
                            cnt_d   = '0;
                            state_d = PRST;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset clears them immediately.
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.dout_valid = (state_q == SQUEEZE);
        bus.dout       = (state_q == SQUEEZE) ? s_q[LANE_W * 32'(cnt_q) +: LANE_W] : '0;
        perm_rst       = (state_q == PRST);
        perm_enable    = (state_q == PERM);
        perm_in        = s_q;
    end

    // State, sponge state and lane counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
